// File: rtl/calc_disp_pkg.sv
// Shared display definitions for the calculator front panel: blank pattern,
// active-low hex segment codes ({g,f,e,d,c,b,a}) and a ceil-log2 helper.
package calc_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to seven-segment decoder, active-low {g,f,e,d,c,b,a}.
module hex_to_7seg
  import calc_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (nibble)
      4'h0: seg_n = SEG_HEX_0;
      4'h1: seg_n = SEG_HEX_1;
      4'h2: seg_n = SEG_HEX_2;
      4'h3: seg_n = SEG_HEX_3;
      4'h4: seg_n = SEG_HEX_4;
      4'h5: seg_n = SEG_HEX_5;
      4'h6: seg_n = SEG_HEX_6;
      4'h7: seg_n = SEG_HEX_7;
      4'h8: seg_n = SEG_HEX_8;
      4'h9: seg_n = SEG_HEX_9;
      4'hA: seg_n = SEG_HEX_A;
      4'hB: seg_n = SEG_HEX_B;
      4'hC: seg_n = SEG_HEX_C;
      4'hD: seg_n = SEG_HEX_D;
      4'hE: seg_n = SEG_HEX_E;
      4'hF: seg_n = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner: prescaler, slot counter, per-slot
// snapshot, dead time, PWM brightness and registered anode/cathode drives.
module seg_scan_ctrl
  import calc_disp_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int CLK_DIV          = 100000,
  parameter int BLANK_CYC        = 2,
  parameter int BRIGHT_W         = 4,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [BRIGHT_W-1:0]           brightness,
  input  logic [4*NUM_DIGITS-1:0]       digit_data,
  input  logic [NUM_DIGITS-1:0]         dp,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [6:0]                    seg,
  output logic                          dp_n,
  output logic [clog2(NUM_DIGITS)-1:0]  slot
);

  localparam int SLOT_W = clog2(NUM_DIGITS);
  localparam int P_W    = clog2(CLK_DIV);
  localparam int ON_W   = P_W + 1;

  localparam logic [P_W-1:0]        P_LAST    = P_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

  // Lit cycles per slot for a brightness code; all-ones yields CLK_DIV-BLANK_CYC.
  function automatic logic [ON_W-1:0] calc_on(input logic [BRIGHT_W-1:0] b);
    logic [31:0] prod;
    prod = (32'(b) + 32'd1) * 32'(CLK_DIV - BLANK_CYC);
    return ON_W'(prod >> BRIGHT_W);
  endfunction

  logic [P_W-1:0]        p_q, p_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [3:0]            nib_q, nib_d;
  logic                  dp_snap_q, dp_snap_d;
  logic                  den_q, den_d;
  logic [ON_W-1:0]       on_cyc_q, on_cyc_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;

  logic [SLOT_W-1:0]     dig_idx;
  logic                  at_start;
  logic [3:0]            nib_live;
  logic                  dp_live;
  logic                  den_live;
  logic [3:0]            nib_eff;
  logic                  dp_eff;
  logic                  den_eff;
  logic [ON_W-1:0]       on_eff;
  logic [6:0]            dec_seg;
  logic                  lit;
  int                    p_int;
  int                    on_int;

  // Slot 0 is the leftmost digit so the scan runs left to right.
  assign dig_idx  = SLOT_LAST - slot_q;
  assign at_start = (p_q == '0);

  always_comb begin
    nib_live = '0;
    dp_live  = 1'b0;
    den_live = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (SLOT_W'(i) == dig_idx) begin
        nib_live = digit_data[4*i +: 4];
        dp_live  = dp[i];
        den_live = digit_en[i];
      end
    end
  end

  // During p==0 the snapshot is being loaded, so the live inputs stand in for it.
  assign nib_eff = at_start ? nib_live            : nib_q;
  assign dp_eff  = at_start ? dp_live             : dp_snap_q;
  assign den_eff = at_start ? den_live            : den_q;
  assign on_eff  = at_start ? calc_on(brightness) : on_cyc_q;

  hex_to_7seg u_hex_to_7seg (
    .nibble (nib_eff),
    .seg_n  (dec_seg)
  );

  assign p_int  = int'(p_q);
  assign on_int = int'(on_eff);
  assign lit    = en && den_eff && (p_int >= BLANK_CYC) && (p_int < BLANK_CYC + on_int);

  always_comb begin
    p_d    = p_q;
    slot_d = slot_q;
    if (!en) begin
      p_d    = '0;
      slot_d = '0;
    end else if (p_q == P_LAST) begin
      p_d    = '0;
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end else begin
      p_d = p_q + 1'b1;
    end
  end

  always_comb begin
    nib_d     = nib_q;
    dp_snap_d = dp_snap_q;
    den_d     = den_q;
    on_cyc_d  = on_cyc_q;
    if (en && at_start) begin
      nib_d     = nib_live;
      dp_snap_d = dp_live;
      den_d     = den_live;
      on_cyc_d  = calc_on(brightness);
    end
  end

  // Only the selected digit's anode can ever be driven active, so the
  // registered anode word is one-hot or idle in every cycle.
  always_comb begin
    anode_d = ANODE_OFF;
    seg_d   = SEG_BLANK;
    dp_n_d  = 1'b1;
    if (lit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (SLOT_W'(i) == dig_idx) begin
          anode_d[i] = ~ANODE_ACTIVE_LOW;
        end
      end
      seg_d  = dec_seg;
      dp_n_d = ~dp_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q       <= '0;
      slot_q    <= '0;
      nib_q     <= '0;
      dp_snap_q <= 1'b0;
      den_q     <= 1'b0;
      on_cyc_q  <= '0;
      anode_q   <= ANODE_OFF;
      seg_q     <= SEG_BLANK;
      dp_n_q    <= 1'b1;
    end else begin
      p_q       <= p_d;
      slot_q    <= slot_d;
      nib_q     <= nib_d;
      dp_snap_q <= dp_snap_d;
      den_q     <= den_d;
      on_cyc_q  <= on_cyc_d;
      anode_q   <= anode_d;
      seg_q     <= seg_d;
      dp_n_q    <= dp_n_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign dp_n  = dp_n_q;
  assign slot  = slot_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed front-panel scenarios plus randomized
// inputs, checked against a linear-time reference model of the scan.
module tb_seg_scan_ctrl;

  localparam int ND        = 4;
  localparam int CLK_DIV   = 8;
  localparam int BLANK_CYC = 1;
  localparam int BRIGHT_W  = 2;
  localparam logic [ND-1:0] INACT = 4'hF;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic [BRIGHT_W-1:0]  brightness;
  logic [4*ND-1:0]      digit_data;
  logic [ND-1:0]        dp;
  logic [ND-1:0]        digit_en;
  logic [ND-1:0]        anode;
  logic [6:0]           seg;
  logic                 dp_n;
  logic [1:0]           slot;

  seg_scan_ctrl #(
    .NUM_DIGITS       (ND),
    .CLK_DIV          (CLK_DIV),
    .BLANK_CYC        (BLANK_CYC),
    .BRIGHT_W         (BRIGHT_W),
    .ANODE_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .brightness (brightness),
    .digit_data (digit_data),
    .dp         (dp),
    .digit_en   (digit_en),
    .anode      (anode),
    .seg        (seg),
    .dp_n       (dp_n),
    .slot       (slot)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: the scan is a linear count of enabled cycles since restart
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          m_t;
  logic [3:0]  m_nib;
  logic        m_dp;
  logic        m_den;
  int          m_br;
  logic [ND-1:0] e_anode;
  logic [6:0]  e_seg;
  logic        e_dpn;
  int          e_slot;
  int          lit_cnt;
  int          dp_cnt;

  function automatic int cur_p();
    return m_t % CLK_DIV;
  endfunction

  function automatic int cur_slot();
    return (m_t / CLK_DIV) % ND;
  endfunction

  task automatic model_reset();
    m_t = 0; m_nib = '0; m_dp = 1'b0; m_den = 1'b0; m_br = 0;
    e_anode = INACT; e_seg = 7'h7F; e_dpn = 1'b1; e_slot = 0;
  endtask

  // Predicts the outputs after the coming edge from the current inputs.
  task automatic model_step();
    int p, k, d, on;
    bit is_lit;
    if (!en) begin
      e_anode = INACT; e_seg = 7'h7F; e_dpn = 1'b1;
      m_t = 0;
    end else begin
      p = cur_p();
      k = cur_slot();
      d = ND - 1 - k;
      if (p == 0) begin
        m_nib = digit_data[4*d +: 4];
        m_dp  = dp[d];
        m_den = digit_en[d];
        m_br  = int'(brightness);
      end
      on = ((m_br + 1) * (CLK_DIV - BLANK_CYC)) >> BRIGHT_W;
      is_lit = m_den && (p >= BLANK_CYC) && (p < BLANK_CYC + on);
      e_anode = INACT;
      if (is_lit) e_anode[d] = 1'b0;
      e_seg = is_lit ? hex_tab[m_nib] : 7'h7F;
      e_dpn = is_lit ? ~m_dp : 1'b1;
      m_t = m_t + 1;
    end
    e_slot = cur_slot();
  endtask

  // Driver: one clock cycle, then check every output against the model
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("anode", 32'(anode), 32'(e_anode));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp_n", 32'(dp_n), 32'(e_dpn));
    chk("slot", 32'(slot), 32'(e_slot));
    chk("onehot", 32'($countones(anode ^ INACT) <= 1), 32'd1);
    if (anode !== INACT) lit_cnt++;
    if (dp_n === 1'b0) dp_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic advance_to(input int s, input int p);
    int n = 0;
    while (!(cur_slot() == s && cur_p() == p) && n < 64) begin
      tick();
      n++;
    end
    chk("reach_state", 32'(cur_slot() == s && cur_p() == p), 32'd1);
  endtask

  logic [ND-1:0] order_q[$];
  int cnt_a2;

  initial begin
    rst_n = 1'b0; en = 1'b0; brightness = '0; digit_data = '0; dp = '0; digit_en = '0;
    lit_cnt = 0; dp_cnt = 0;
    model_reset();
    #12;
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp_n", 32'(dp_n), 32'd1);
    chk("rst_slot", 32'(slot), 32'd0);

    // Reset and scan
    en = 1'b1; digit_data = 16'h1234; brightness = 2'd3; digit_en = 4'hF;
    rst_n = 1'b1;
    for (int i = 0; i < 2*ND*CLK_DIV; i++) begin
      tick();
      if (anode !== INACT && (order_q.size() == 0 || order_q[$] !== anode)) order_q.push_back(anode);
      case (anode)
        4'b0111: chk("s1_seg_d3", 32'(seg), 32'h79);
        4'b1011: chk("s1_seg_d2", 32'(seg), 32'h24);
        4'b1101: chk("s1_seg_d1", 32'(seg), 32'h30);
        4'b1110: chk("s1_seg_d0", 32'(seg), 32'h19);
        default: ;
      endcase
    end
    chk("s1_order_len", 32'(order_q.size() >= 4), 32'd1);
    if (order_q.size() >= 4) begin
      chk("s1_order0", 32'(order_q[0]), 32'b0111);
      chk("s1_order1", 32'(order_q[1]), 32'b1011);
      chk("s1_order2", 32'(order_q[2]), 32'b1101);
      chk("s1_order3", 32'(order_q[3]), 32'b1110);
    end
    lit_cnt = 0;
    ticks(ND*CLK_DIV);
    chk("b3_lit", 32'(lit_cnt), 32'd28);

    // Brightness
    brightness = 2'd0;
    ticks(40);
    lit_cnt = 0;
    ticks(ND*CLK_DIV);
    chk("b0_lit", 32'(lit_cnt), 32'd4);
    brightness = 2'd1;
    ticks(40);
    lit_cnt = 0;
    ticks(ND*CLK_DIV);
    chk("b1_lit", 32'(lit_cnt), 32'd12);

    // Blanking and decimal point
    brightness = 2'd3; digit_en = 4'b1011; dp = 4'b0001;
    ticks(40);
    dp_cnt = 0; cnt_a2 = 0;
    for (int i = 0; i < ND*CLK_DIV; i++) begin
      tick();
      if (anode === 4'b1011) cnt_a2++;
      if (dp_n === 1'b0) chk("dp_pos", 32'(anode), 32'b1110);
    end
    chk("blank_d2", 32'(cnt_a2), 32'd0);
    chk("dp_lit", 32'(dp_cnt), 32'd7);

    // Snapshot stability
    digit_en = 4'hF; dp = '0; digit_data = 16'h1234;
    ticks(40);
    advance_to(0, 4);
    digit_data = 16'hABCD;
    for (int i = 0; i < 2*CLK_DIV; i++) begin
      tick();
      if (anode === 4'b0111) chk("snap_hold", 32'(seg), 32'h79);
      if (anode === 4'b1011) chk("snap_new", 32'(seg), 32'h03);
    end

    // Enable drop mid-slot
    advance_to(2, 5);
    en = 1'b0;
    tick();
    chk("en_off_anode", 32'(anode), 32'hF);
    chk("en_off_slot", 32'(slot), 32'd0);
    ticks(3);
    en = 1'b1;
    tick();
    chk("en_on_slot", 32'(slot), 32'd0);
    ticks(CLK_DIV);

    // Asynchronous reset mid-slot
    advance_to(3, 3);
    tick();
    chk("pre_rst_anode", 32'(anode), 32'b1110);
    rst_n = 1'b0;
    #2;
    chk("arst_anode", 32'(anode), 32'hF);
    chk("arst_seg", 32'(seg), 32'h7F);
    chk("arst_dp_n", 32'(dp_n), 32'd1);
    chk("arst_slot", 32'(slot), 32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    ticks(ND*CLK_DIV + 4);

    // Randomized inputs
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) brightness = BRIGHT_W'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) digit_en = ND'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) dp = ND'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) digit_data = 16'($urandom);
      en = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
